// File: rtl/dmem_burst_master.sv
// dmem_burst_master: burst load/store sequencer for a single-port 32x32 data memory
// with one-cycle registered reads and synchronous writes.
module dmem_burst_master #(
  parameter int ADDR_W = 5,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [31:0]       wdata,
  output logic              rdata_valid,
  output logic [31:0]       rdata,
  output logic              done,
  output logic [31:0]       mem_address,
  output logic [31:0]       mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       mem_rdata
);
  typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_idx;
  logic [LEN_W:0]    r_rem;
  logic              r_rd_pend;
  logic              w_last;
  assign w_last = r_rem == (LEN_W+1)'(1);
  always_ff @(posedge clk)
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb
    w_next = r_state == IDLE ? (req_valid ? (req_write ? WR : RD) : IDLE) :
             r_state == WR   ? (wdata_valid && w_last ? DONE : WR) :
             r_state == RD   ? (w_last ? DONE : RD) : IDLE;
  always_comb begin
    req_ready   = r_state == IDLE;
    wdata_ready = r_state == WR;
    mem_write   = r_state == WR && wdata_valid;
    mem_read    = r_state == RD;
    mem_address = (mem_read || wdata_ready) ? {{(32-ADDR_W){1'b0}}, r_idx} : '0;
    mem_wdata   = wdata_ready ? wdata : '0;
    done        = r_state == DONE;
  end
  // a zero length field encodes the maximum burst of 2^LEN_W words
  always_ff @(posedge clk)
    if (!reset) begin
      r_idx     <= '0;
      r_rem     <= '0;
      r_rd_pend <= 1'b0;
    end else begin
      r_rd_pend <= mem_read;
      if (req_valid && req_ready) begin
        r_idx <= req_addr;
        r_rem <= req_len == '0 ? {1'b1, {LEN_W{1'b0}}} : {1'b0, req_len};
      end else if (mem_read || mem_write) begin
        r_idx <= r_idx + ADDR_W'(1);
        r_rem <= r_rem - (LEN_W+1)'(1);
      end
    end
  assign rdata_valid = r_rd_pend;
  assign rdata       = r_rd_pend ? mem_rdata : '0;
endmodule

// File: tb/tb_dmem_burst_master.sv
// tb_dmem_burst_master: randomized burst traffic against a reference memory image,
// with a behavioural memory model attached to the controller's memory pins.
module tb_dmem_burst_master;
  logic        clk = 0, reset = 0, req_valid = 0, req_write = 0, wdata_valid = 0;
  logic [4:0]  req_addr = 0;
  logic [3:0]  req_len = 0;
  logic [31:0] wdata = 0, mem_rdata = 0;
  logic        req_ready, wdata_ready, rdata_valid, done, mem_read, mem_write;
  logic [31:0] rdata, mem_address, mem_wdata;
  logic [31:0] mem [32];
  logic [31:0] ref_mem [32];
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  dmem_burst_master dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata(rdata), .done(done),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_write) mem[mem_address[4:0]] <= mem_wdata;
    if (mem_read) mem_rdata <= mem[mem_address[4:0]];
  end

  task automatic noise_req(input bit noise);
    req_valid = noise;
    if (noise) begin
      req_write = 1'($urandom);
      req_addr  = 5'($urandom);
      req_len   = 4'($urandom);
    end
  endtask

  // gap < 0 gives random stalls; base != 0 gives store data base+k
  task automatic do_burst(input bit wr, input logic [4:0] a, input logic [3:0] l,
                          input int gap, input bit noise, input logic [31:0] base);
    int n, k, c, nv;
    logic wv;
    logic [4:0] ea, ra;
    logic [31:0] d, ed;
    n = (l == 0) ? 16 : int'(l);
    @(negedge clk);
    req_valid = 1; req_write = wr; req_addr = a; req_len = l; wdata_valid = 0;
    #1 checks++;
    if (req_ready !== 1) begin errors++; $display("FAIL accept: req_ready=%b want 1", req_ready); end
    k = 0; c = 0; nv = 0;
    if (wr) begin
      while (k < n) begin
        @(negedge clk); c++;
        noise_req(noise);
        wv = (gap < 0) ? ($urandom_range(0, 2) != 0) : (((c - 1) % (gap + 1)) == 0);
        d = (base != 0) ? base + 32'(k) : $urandom;
        wdata_valid = wv; wdata = d; ea = a + 5'(k);
        #1 checks++;
        if (wdata_ready !== 1 || mem_write !== wv || mem_read !== 0 || done !== 0 || req_ready !== 0) begin
          errors++;
          $display("FAIL store_ctl c=%0d: wr_rdy=%b mw=%b mr=%b done=%b rq_rdy=%b want 1 %b 0 0 0",
                   c, wdata_ready, mem_write, mem_read, done, req_ready, wv);
        end
        if (wv) begin
          checks++;
          if (mem_address !== {27'b0, ea} || mem_wdata !== d) begin
            errors++;
            $display("FAIL store_data k=%0d: addr=%h data=%h want %h %h", k, mem_address, mem_wdata, {27'b0, ea}, d);
          end
          ref_mem[ea] = d;
          k++;
        end
      end
    end else begin
      for (c = 1; c <= n; c++) begin
        @(negedge clk);
        noise_req(noise);
        wdata_valid = 1'($urandom); wdata = $urandom;
        ea = a + 5'(c - 1);
        ra = a + 5'(c - 2);
        ed = (c >= 2) ? ref_mem[ra] : 32'h0;
        #1 checks++;
        if (mem_read !== 1 || mem_write !== 0 || mem_address !== {27'b0, ea} || done !== 0 || req_ready !== 0) begin
          errors++;
          $display("FAIL load_issue c=%0d: mr=%b mw=%b addr=%h done=%b rq_rdy=%b want 1 0 %h 0 0",
                   c, mem_read, mem_write, mem_address, done, req_ready, {27'b0, ea});
        end
        checks++;
        if (rdata_valid !== (c >= 2) || rdata !== ed) begin
          errors++;
          $display("FAIL load_data c=%0d: valid=%b rdata=%h want %b %h", c, rdata_valid, rdata, c >= 2, ed);
        end
        nv += int'(rdata_valid);
      end
    end
    @(negedge clk);
    noise_req(noise);
    wdata_valid = 1'($urandom);
    #1 checks++;
    if (done !== 1 || req_ready !== 0 || mem_read !== 0 || mem_write !== 0 || mem_address !== 0 || mem_wdata !== 0) begin
      errors++;
      $display("FAIL done: done=%b rq_rdy=%b mr=%b mw=%b addr=%h wd=%h want 1 0 0 0 0 0",
               done, req_ready, mem_read, mem_write, mem_address, mem_wdata);
    end
    if (!wr) begin
      ra = a + 5'(n - 1);
      nv += int'(rdata_valid);
      checks++;
      if (rdata_valid !== 1 || rdata !== ref_mem[ra]) begin
        errors++; $display("FAIL load_last: valid=%b rdata=%h want 1 %h", rdata_valid, rdata, ref_mem[ra]);
      end
      checks++;
      if (nv != n) begin errors++; $display("FAIL load_count: pulses=%0d want %0d", nv, n); end
    end
    @(negedge clk);
    req_valid = 0; wdata_valid = 0;
    #1 checks++;
    if (req_ready !== 1 || done !== 0 || rdata_valid !== 0 || mem_write !== 0) begin
      errors++;
      $display("FAIL idle: rq_rdy=%b done=%b valid=%b mw=%b want 1 0 0 0", req_ready, done, rdata_valid, mem_write);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if (req_ready !== 1 || wdata_ready !== 0 || rdata_valid !== 0 || done !== 0 || mem_read !== 0 ||
        mem_write !== 0 || mem_address !== 0 || mem_wdata !== 0 || rdata !== 0) begin
      errors++;
      $display("FAIL %s: rq_rdy=%b wr_rdy=%b valid=%b done=%b mr=%b mw=%b addr=%h wd=%h rd=%h want 1 and all 0",
               tag, req_ready, wdata_ready, rdata_valid, done, mem_read, mem_write, mem_address, mem_wdata, rdata);
    end
  endtask

  task automatic test_reset;
    reset = 0;
    repeat (2) begin
      @(negedge clk);
      noise_req(1);
      wdata_valid = 1'($urandom); wdata = $urandom;
      #1 check_idle_outputs("reset_hold");
    end
    @(negedge clk);
    reset = 1; req_valid = 0; wdata_valid = 0;
    #1 check_idle_outputs("reset_release");
  endtask

  task automatic test_store_load;
    do_burst(1, 5'd4, 4'd3, 0, 0, 32'hA);
    do_burst(0, 5'd4, 4'd3, 0, 0, 32'h0);
  endtask

  task automatic test_wrap_max;
    do_burst(0, 5'd30, 4'd0, 0, 0, 32'h0);
    do_burst(1, 5'd29, 4'd0, 0, 0, 32'h0);
    do_burst(0, 5'd20, 4'd0, 0, 0, 32'h0);
  endtask

  task automatic test_stall;
    do_burst(1, 5'd10, 4'd2, 3, 0, 32'h0);
    do_burst(0, 5'd10, 4'd2, 0, 0, 32'h0);
  endtask

  task automatic test_abort;
    @(negedge clk);
    req_valid = 1; req_write = 0; req_addr = 5'($urandom); req_len = 4'd8;
    #1 checks++;
    if (req_ready !== 1) begin errors++; $display("FAIL abort_accept: req_ready=%b want 1", req_ready); end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); req_valid = 0;
      #1 checks++;
      if (mem_read !== 1) begin errors++; $display("FAIL abort_issue c=%0d: mr=%b want 1", c, mem_read); end
    end
    @(negedge clk); reset = 0;
    @(negedge clk); reset = 1;
    #1 check_idle_outputs("abort_after");
    repeat (3) begin
      @(negedge clk);
      #1 checks++;
      if (done !== 0 || rdata_valid !== 0) begin
        errors++; $display("FAIL abort_quiet: done=%b valid=%b want 0 0", done, rdata_valid);
      end
    end
    do_burst(1, 5'($urandom), 4'd1, 0, 0, 32'h0);
  endtask

  task automatic test_busy_ignore;
    do_burst(0, 5'd7, 4'd5, 0, 1, 32'h0);
    do_burst(1, 5'd17, 4'd4, 1, 1, 32'h0);
    do_burst(0, 5'd17, 4'd4, 0, 0, 32'h0);
  endtask

  task automatic test_random;
    repeat (10) do_burst(1'($urandom), 5'($urandom), 4'($urandom), -1, 1'($urandom), 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    test_reset;
    test_store_load;
    test_wrap_max;
    test_stall;
    test_abort;
    test_busy_ignore;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_burst_master.md
# dmem_burst_master

Initiator-side controller for the single-port data memory (32 x 32-bit, word-indexed by address bits [4:0], synchronous write, one-cycle registered read). It accepts burst load/store commands from the datapath over a valid/ready request channel. It streams store data in and load data out, one word per cycle. It sequences the memory's Address/WriteData/MemRead/MemWrite pins and captures ReadData one cycle after each read.

## Interface
- ADDR_W, 5, memory word-index width; the index wraps modulo 2^ADDR_W
- LEN_W, 4, burst length field width; req_len = 0 means 2^LEN_W words
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low)
- req_valid  in  1  command valid
- req_ready  out  1  command accepted when req_valid & req_ready
- req_write  in  1  1 = store burst, 0 = load burst
- req_addr  in  ADDR_W  starting word index
- req_len  in  LEN_W  word count (0 -> 2^LEN_W)
- wdata_valid  in  1  store word valid
- wdata_ready  out  1  store word accepted when wdata_valid & wdata_ready
- wdata  in  32  store word
- rdata_valid  out  1  load word present on rdata this cycle
- rdata  out  32  load word; 0 when rdata_valid = 0
- done  out  1  one-cycle burst-complete pulse
- mem_address  out  32  to memory Address; {zeros, cur_idx}
- mem_wdata  out  32  to memory WriteData
- mem_read  out  1  to memory MemRead
- mem_write  out  1  to memory MemWrite
- mem_rdata  in  32  from memory ReadData

## Operation
- State register: IDLE, WR, RD, DONE. Registered cur_idx (ADDR_W), remaining (LEN_W+1), op.
- IDLE: req_ready = 1. On handshake, latch cur_idx = req_addr and remaining = (req_len == 0 ? 2^LEN_W : req_len). Go to WR if req_write, else RD.
- WR: wdata_ready = 1. When wdata_valid = 1: mem_write = 1, mem_address = cur_idx, mem_wdata = wdata (combinational), then cur_idx += 1 and remaining -= 1. When wdata_valid = 0: mem_write = 0 and no state change (indefinite stall allowed). When the last word is accepted, go to DONE.
- RD: mem_read = 1 every cycle with mem_address = cur_idx. Then cur_idx += 1 and remaining -= 1. After the last issue, go to DONE. A registered rd_pend flag copies mem_read. rdata_valid = rd_pend and rdata = mem_rdata when rd_pend, else 0.
- DONE: done = 1 for one cycle. For load bursts the final rdata_valid falls in this same cycle. Next state is IDLE. req_ready = 0, so back-to-back commands have a one-cycle gap after DONE.
- Index wrap: cur_idx is ADDR_W bits and wraps 31 -> 0 with no error. mem_address[31:ADDR_W] = 0.
- req_valid outside IDLE is ignored and not latched. wdata_valid outside WR is ignored.
- All memory-side outputs are 0 in IDLE and DONE. mem_read and mem_write are never high together.

## Timing
- Reset: the first rising edge sampling reset = 0 forces IDLE, cur_idx = 0, remaining = 0, rd_pend = 0. Next cycle: req_ready = 1; wdata_ready, rdata_valid, done, mem_read, mem_write = 0; mem_address, mem_wdata, rdata = 0.
- Reset mid-burst aborts with no done pulse. Writes already clocked into memory stay. A pending read's rdata_valid is suppressed.
- Load of N words: handshake at edge 0; reads issued in cycles 1..N; rdata_valid in cycles 2..N+1; done in cycle N+1. Total N+1 cycles after accept; throughput one word per cycle.
- Store of N words with wdata_valid held high: writes in cycles 1..N, done in cycle N+1. Each wdata stall cycle adds one cycle.
- Memory write commits at the edge ending the cycle where mem_write = 1.

## Test plan
- Reset: hold reset = 0 for 2 cycles with random inputs -> req_ready = 1, every other output 0; no mem_write ever asserted.
- Store then load: store addr 4, len 3, data 0xA, 0xB, 0xC -> mem_write at idx 4, 5, 6 and done in cycle 4. Then load addr 4, len 3 -> rdata 0xA, 0xB, 0xC in cycles 2-4, with done coinciding with 0xC.
- Wrap and max length: load addr 30, len 0 -> 16 reads at idx 30, 31, 0 .. 13; exactly 16 rdata_valid pulses; mem_address upper bits 0.
- Stall: store len 2 with wdata_valid low for 3 cycles between words -> mem_write only on valid cycles; done 6 cycles after accept; no extra writes.
- Abort: start load len 8, drive reset = 0 after the 3rd issue -> IDLE next cycle; no done; rdata_valid 0 after reset. A following store of len 1 completes normally.
- Busy ignore: assert req_valid with a different command during RD -> not accepted (req_ready = 0); burst count and addresses unchanged.
